// File: rtl/tungsten_pkg.sv
// Shared types and defaults for the Tungsten uio pad-bus arbiter.
package tungsten_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TURN,
        ST_XFER,
        ST_RELEASE
    } arb_state_e;

    localparam int DEFAULT_TURN_CYCLES = 1;
    localparam int DEFAULT_HOLD_CYCLES = 2;

    // 0 = core memory path, 1 = debug/host path
    typedef logic port_idx_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tungsten_rr_arb2.sv
// Two-way round-robin picker; the pointer remembers the port granted last.
module tungsten_rr_arb2
    import tungsten_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] pick
);

    port_idx_t last_q;

    always_comb begin
        pick = req;
        if (req == 2'b11) begin
            pick = (last_q == 1'b1) ? 2'b01 : 2'b10;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (update && (req != 2'b00)) begin
            last_q <= pick[1];
        end
    end

endmodule

// File: rtl/tungsten_uio_arbiter.sv
// Tungsten uio pad-bus arbiter: two requesters, bus turnaround, fixed hold window, done pulse.
// Optional write loopback compare is built when UIO_ARB_LOOPBACK_CHECK_EN is defined.
module tungsten_uio_arbiter
    import tungsten_pkg::*;
#(
    parameter int TURN_CYCLES = DEFAULT_TURN_CYCLES,
    parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       req0,
    input  logic       req1,
    input  logic       wr0,
    input  logic       wr1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       done0,
    output logic       done1,
    output logic [7:0] rdata,
    output logic       err,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int CNT_W = $clog2(max2(TURN_CYCLES, HOLD_CYCLES) + 1);
    localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TURN_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wr_q, wr_d;
    logic [7:0]       wdata_q, wdata_d;
    logic [1:0]       gnt_q, gnt_d;
    logic [1:0]       done_q, done_d;
    logic [7:0]       rdata_q, rdata_d;
    logic [7:0]       out_q, out_d;
    logic             oe_q, oe_d;
    logic [1:0]       pick;
    logic             grant_now;
    logic             last_xfer;

    tungsten_rr_arb2 u_rr (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    ({req1, req0}),
        .update (grant_now),
        .pick   (pick)
    );

    assign last_xfer = (state_q == ST_XFER) && (cnt_q == '0);

    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_d      = wr_q;
        wdata_d   = wdata_q;
        gnt_d     = gnt_q;
        done_d    = 2'b00;
        rdata_d   = rdata_q;
        out_d     = out_q;
        oe_d      = oe_q;
        grant_now = 1'b0;

        if ((state_q != ST_IDLE) && !ena) begin
            // Abort: release the pads and drop the grant without a completion.
            state_d = ST_IDLE;
            gnt_d   = 2'b00;
            oe_d    = 1'b0;
            out_d   = 8'h00;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    gnt_d = 2'b00;
                    oe_d  = 1'b0;
                    out_d = 8'h00;
                    if (ena && (req0 || req1)) begin
                        grant_now = 1'b1;
                        gnt_d     = pick;
                        wr_d      = pick[1] ? wr1 : wr0;
                        wdata_d   = pick[1] ? wdata1 : wdata0;
                        cnt_d     = TURN_LOAD;
                        state_d   = ST_TURN;
                    end
                end
                ST_TURN: begin
                    if (cnt_q == '0) begin
                        state_d = ST_XFER;
                        cnt_d   = HOLD_LOAD;
                        oe_d    = wr_q;
                        out_d   = wr_q ? wdata_q : 8'h00;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_XFER: begin
                    if (cnt_q == '0) begin
                        state_d = ST_RELEASE;
                        oe_d    = 1'b0;
                        out_d   = 8'h00;
                        done_d  = gnt_q;
                        if (!wr_q) begin
                            rdata_d = uio_in;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    state_d = ST_IDLE;
                    gnt_d   = 2'b00;
                end
                default: begin
                    state_d = ST_IDLE;
                    gnt_d   = 2'b00;
                    oe_d    = 1'b0;
                    out_d   = 8'h00;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            wdata_q <= 8'h00;
            gnt_q   <= 2'b00;
            done_q  <= 2'b00;
            rdata_q <= 8'h00;
            out_q   <= 8'h00;
            oe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
            out_q   <= out_d;
            oe_q    <= oe_d;
        end
    end

`ifdef UIO_ARB_LOOPBACK_CHECK_EN
    logic err_q;

    // Sticky until reset; visible in the RELEASE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (last_xfer && ena && wr_q && (uio_in != wdata_q)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign gnt0    = gnt_q[0];
    assign gnt1    = gnt_q[1];
    assign done0   = done_q[0];
    assign done1   = done_q[1];
    assign rdata   = rdata_q;
    assign uio_out = out_q;
    assign uio_oe  = {8{oe_q}};

endmodule
